regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits of every entry and data port.
REQ-002 Parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 0; when 1, entry 0 always reads 0 and ignores writes.
REQ-004 Parameter BYPASS, default 1; when 1, a read of an address written in the same cycle returns the write data.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 RA1  input  ADDR_W  read address, port 1.
REQ-008 RA2  input  ADDR_W  read address, port 2.
REQ-009 RD1  output  DATA_W  read data, port 1, combinational from RA1.
REQ-010 RD2  output  DATA_W  read data, port 2, combinational from RA2.
REQ-011 WA1  input  ADDR_W  write address, port 1.
REQ-012 WD1  input  DATA_W  write data, port 1.
REQ-013 WE1  input  1  write enable, port 1.
REQ-014 WA2  input  ADDR_W  write address, port 2.
REQ-015 WD2  input  DATA_W  write data, port 2.
REQ-016 WE2  input  1  write enable, port 2.
REQ-017 READY  output  1  high when the array is initialised and accepting writes.

Function
REQ-018 Two-state controller: CLEAR and RUN; CLEAR has a clear index CI of ADDR_W bits.
REQ-019 CLEAR writes 0 to entry CI each cycle and increments CI; on the cycle CI = DEPTH-1 is cleared, the state moves to RUN.
REQ-020 Clearing all DEPTH entries takes exactly DEPTH cycles after rst deasserts; READY rises on the following edge.
REQ-021 READY is low in CLEAR and high in RUN.
REQ-022 While READY is low, WE1/WE2 are ignored and RD1/RD2 return 0.
REQ-023 In RUN, WE1 high writes WD1 to entry WA1 at the rising edge; WE2 likewise for WD2/WA2.
REQ-024 When WE1 and WE2 are both high with WA1 = WA2, port 2 wins: the entry takes WD2.
REQ-025 When BYPASS = 1 and READY is high, RDn = WD2 if WE2 and WA2 = RAn, else WD1 if WE1 and WA1 = RAn, else the stored entry.
REQ-026 When BYPASS = 0, RDn returns the stored entry; new data is visible the cycle after the write.
REQ-027 When ZERO_REG = 1, writes to address 0 are discarded, and RDn = 0 for RAn = 0 regardless of bypass.
REQ-028 Both read ports may address the same entry simultaneously; each returns identical data.
REQ-029 No address is out of range; the full 2**ADDR_W space is implemented.

Reset
REQ-030 rst high at a rising edge forces state CLEAR and CI = 0, and drives READY low from that edge.
REQ-031 While rst is held high, CI stays 0 and entry 0 is written 0 each cycle.
REQ-032 rst asserted mid-RUN or mid-CLEAR restarts the full clear from entry 0; prior contents are lost.
REQ-033 Writes presented in the same cycle as rst are ignored.
REQ-034 Memory contents and READY before the first rst are undefined, so the bench applies rst first.

Verification
REQ-035 Defaults: rst for 1 cycle, then idle -> READY low for exactly 64 cycles, then high; every address reads 0.
REQ-036 After READY: WE1=1, WA1=5, WD1=0xDEADBEEF, RA1=5 -> RD1=0xDEADBEEF in the same cycle (bypass); RA2=5 next cycle gives RD2=0xDEADBEEF.
REQ-037 WE1=WE2=1, WA1=WA2=9, WD1=0x11111111, WD2=0x22222222 -> RD1 at RA1=9 is 0x22222222 in that cycle and after.
REQ-038 ZERO_REG=1: write 0xFFFFFFFF to address 0 -> RD1 at RA1=0 is 0 in the same cycle and thereafter; BYPASS=0: write 0x1234 to 7 -> RD1 at RA1=7 is the old value that cycle and 0x1234 next cycle.
REQ-039 Fill addresses 0..63 with their index, pulse rst at cycle 20 of a second clear -> READY low for 64 cycles from the final rst deassert; all reads return 0.
REQ-040 During CLEAR assert WE1=1, WA1=3, WD1=0xAA -> after READY, address 3 reads 0.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param
//   Parameterised two-read / two-write register file. It clears itself after
//   every reset, then accepts writes.
//
//   A small controller walks a clear index across the whole array after
//   reset. READY goes high only once every entry holds zero. While the array
//   is clearing, writes are dropped and both read ports return zero.
//
//   Parameters
//     DATA_W    width of each entry and of every data port
//     ADDR_W    address width; DEPTH = 2**ADDR_W entries
//     ZERO_REG  1: entry 0 always reads 0 and ignores writes
//     BYPASS    1: a read of an address written this cycle returns the write data
//
//   Ports
//     clk            sole clock, rising edge
//     rst            synchronous active-high reset, restarts the clear
//     RA1, RA2       read addresses
//     RD1, RD2       read data, combinational from RA1/RA2
//     WA1, WD1, WE1  write port 1
//     WA2, WD2, WE2  write port 2 (wins over port 1 on an address collision)
//     READY          array initialised and accepting writes
//
//   state | meaning
//   ------+------------------------------------------------------------
//   CLEAR | zeroing entry ci each cycle; writes ignored; reads return 0
//   RUN   | normal operation; READY high

module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [DATA_W-1:0] WD1,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WA2,
    input  logic [DATA_W-1:0] WD2,
    input  logic              WE2,
    output logic              READY
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ci;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr1;
    logic wr2;

    // ------------------------------------------------------------------
    // Controller
    // READY is registered alongside the state, so it goes high on the same
    // edge that clears the last entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ci    <= '0;
            READY <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (ci == LAST_IDX) begin
                        state <= RUN;
                        READY <= 1'b1;
                        ci    <= '0;
                    end else begin
                        ci <= ci + ADDR_W'(1);
                    end
                end
                RUN: begin
                    state <= RUN;
                    READY <= 1'b1;
                end
                default: begin
                    state <= CLEAR;
                    ci    <= '0;
                    READY <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write qualification. Writes count only in RUN. With ZERO_REG set,
    // writes to entry 0 are dropped here, so the zero entry never needs a
    // special read path for stored data.
    // ------------------------------------------------------------------
    always_comb begin
        wr1 = 1'b0;
        wr2 = 1'b0;
        if (state == RUN) begin
            wr1 = WE1 && !((ZERO_REG != 0) && (WA1 == '0));
            wr2 = WE2 && !((ZERO_REG != 0) && (WA2 == '0));
        end
    end

    // ------------------------------------------------------------------
    // Storage. While rst is held, ci sits at 0, so entry 0 is rewritten
    // with zero each cycle. Port 2 is written last, so it wins when both
    // ports target the same entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
        end else if (state == CLEAR) begin
            mem[ci] <= '0;
        end else begin
            if (wr1) begin
                mem[WA1] <= WD1;
            end
            if (wr2) begin
                mem[WA2] <= WD2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports. The bypass priority matches the write priority: port 2
    // data first, then port 1 data, then the stored entry. wr1/wr2 already
    // exclude entry 0 under ZERO_REG. The explicit zero check also covers
    // the bypass case.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] ra [2];
    logic [DATA_W-1:0] rd [2];

    assign ra[0] = RA1;
    assign ra[1] = RA2;
    assign RD1   = rd[0];
    assign RD2   = rd[1];

    for (genvar p = 0; p < 2; p++) begin : g_read
        always_comb begin
            rd[p] = '0;
            if (state != RUN) begin
                rd[p] = '0;
            end else if ((ZERO_REG != 0) && (ra[p] == '0)) begin
                rd[p] = '0;
            end else if ((BYPASS != 0) && wr2 && (WA2 == ra[p])) begin
                rd[p] = WD2;
            end else if ((BYPASS != 0) && wr1 && (WA1 == ra[p])) begin
                rd[p] = WD1;
            end else begin
                rd[p] = mem[ra[p]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param. Three instances share the same stimulus:
//   dut    default parameters (ZERO_REG=0, BYPASS=1)
//   dut_zb ZERO_REG=1, BYPASS=0
//   dut_zy ZERO_REG=1, BYPASS=1
// Inputs change 1 ns after a rising edge. Outputs are sampled 4 ns later,
// well before the next edge.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  ra1 = '0, ra2 = '0, wa1 = '0, wa2 = '0;
    logic [31:0] wd1 = '0, wd2 = '0;
    logic        we1 = 1'b0, we2 = 1'b0;

    logic [31:0] rd1, rd2, rd1_zb, rd2_zb, rd1_zy, rd2_zy;
    logic        ready, ready_zb, ready_zy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_param dut (
        .clk(clk), .rst(rst), .RA1(ra1), .RA2(ra2), .RD1(rd1), .RD2(rd2),
        .WA1(wa1), .WD1(wd1), .WE1(we1), .WA2(wa2), .WD2(wd2), .WE2(we2),
        .READY(ready)
    );

    regfile_param #(.ZERO_REG(1), .BYPASS(0)) dut_zb (
        .clk(clk), .rst(rst), .RA1(ra1), .RA2(ra2), .RD1(rd1_zb), .RD2(rd2_zb),
        .WA1(wa1), .WD1(wd1), .WE1(we1), .WA2(wa2), .WD2(wd2), .WE2(we2),
        .READY(ready_zb)
    );

    regfile_param #(.ZERO_REG(1), .BYPASS(1)) dut_zy (
        .clk(clk), .rst(rst), .RA1(ra1), .RA2(ra2), .RD1(rd1_zy), .RD2(rd2_zy),
        .WA1(wa1), .WD1(wd1), .WE1(we1), .WA2(wa2), .WD2(wd2), .WE2(we2),
        .READY(ready_zy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pulse rst for one edge, then count edges until READY rises (bounded).
    task automatic reset_and_wait(input string tag);
        int cnt;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b0 || ready_zb !== 1'b0 || ready_zy !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_after_rst got %b%b%b want 000", tag, ready, ready_zb, ready_zy);
        end
        cnt = 0;
        while (ready !== 1'b1 && cnt < 200) begin
            cyc();
            cnt++;
        end
        checks++;
        if (cnt !== 64) begin
            errors++;
            $display("FAIL %s ready_low_cycles got %0d want 64", tag, cnt);
        end
        checks++;
        if (ready_zb !== 1'b1 || ready_zy !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_variants got %b%b want 11", tag, ready_zb, ready_zy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 64; i++) begin
            ra1 = 6'(i);
            ra2 = 6'(63 - i);
            #1;
            checks++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0 || rd1_zb !== 32'h0 || rd2_zb !== 32'h0 ||
                rd1_zy !== 32'h0 || rd2_zy !== 32'h0) begin
                errors++;
                $display("FAIL %s zero_read addr %0d got %h %h %h %h %h %h want 0",
                         tag, i, rd1, rd2, rd1_zb, rd2_zb, rd1_zy, rd2_zy);
            end
        end
    endtask

    // Initial clear. WE1 stays asserted at address 3 for the whole clear and
    // must have no effect.
    task automatic test_reset();
        we1 = 1'b1; wa1 = 6'd3; wd1 = 32'hAA; ra1 = 6'd3;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        repeat (10) cyc();
        #4;
        checks++;
        if (ready !== 1'b0 || rd1 !== 32'h0) begin
            errors++;
            $display("FAIL reset mid_clear got ready=%b rd1=%h want 0 0", ready, rd1);
        end
        cyc();
        reset_and_wait("reset");
        we1 = 1'b0;
        check_all_zero("reset");
        ra1 = 6'd3;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin
            errors++;
            $display("FAIL clear_write_ignored got %h want 0", rd1);
        end
    endtask

    task automatic test_bypass();
        cyc();
        we1 = 1'b1; wa1 = 6'd5; wd1 = 32'hDEADBEEF; ra1 = 6'd5;
        #4;
        checks++;
        if (rd1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle got %h want deadbeef", rd1);
        end
        checks++;
        if (rd1_zb !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_same_cycle got %h want 0", rd1_zb);
        end
        cyc();
        we1 = 1'b0; ra2 = 6'd5;
        #4;
        checks++;
        if (rd2 !== 32'hDEADBEEF || rd2_zb !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_next_cycle got %h %h want deadbeef", rd2, rd2_zb);
        end
    endtask

    task automatic test_collision();
        cyc();
        we1 = 1'b1; we2 = 1'b1; wa1 = 6'd9; wa2 = 6'd9;
        wd1 = 32'h11111111; wd2 = 32'h22222222; ra1 = 6'd9; ra2 = 6'd9;
        #4;
        checks++;
        if (rd1 !== 32'h22222222 || rd2 !== 32'h22222222) begin
            errors++;
            $display("FAIL collision_bypass got %h %h want 22222222", rd1, rd2);
        end
        cyc();
        we1 = 1'b0; we2 = 1'b0;
        #4;
        checks++;
        if (rd1 !== 32'h22222222 || rd1_zb !== 32'h22222222 || rd2_zy !== 32'h22222222) begin
            errors++;
            $display("FAIL collision_stored got %h %h %h want 22222222", rd1, rd1_zb, rd2_zy);
        end
        ra1 = 6'd5;
        #1;
        checks++;
        if (rd1 !== 32'hDEADBEEF || rd2 !== 32'h22222222) begin
            errors++;
            $display("FAIL dual_port_distinct got %h %h want deadbeef 22222222", rd1, rd2);
        end
    endtask

    task automatic test_zero_reg();
        cyc();
        we1 = 1'b1; wa1 = 6'd0; wd1 = 32'hFFFFFFFF; ra1 = 6'd0;
        we2 = 1'b0;
        #4;
        checks++;
        if (rd1_zy !== 32'h0 || rd1_zb !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_same_cycle got %h %h want 0", rd1_zy, rd1_zb);
        end
        checks++;
        if (rd1 !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL entry0_normal_bypass got %h want ffffffff", rd1);
        end
        cyc();
        we1 = 1'b0; we2 = 1'b1; wa2 = 6'd0; wd2 = 32'h5A5A5A5A;
        #4;
        checks++;
        if (rd1_zy !== 32'h0 || rd1_zb !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_port2 got %h %h want 0", rd1_zy, rd1_zb);
        end
        cyc();
        we2 = 1'b0;
        #4;
        checks++;
        if (rd1_zy !== 32'h0 || rd1_zb !== 32'h0 || rd1 !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL zero_reg_after got %h %h %h want 0 0 5a5a5a5a", rd1_zy, rd1_zb, rd1);
        end
    endtask

    task automatic test_no_bypass();
        cyc();
        we1 = 1'b1; wa1 = 6'd7; wd1 = 32'h55;
        cyc();
        wd1 = 32'h1234; ra1 = 6'd7;
        #4;
        checks++;
        if (rd1_zb !== 32'h55) begin
            errors++;
            $display("FAIL nobypass_old_value got %h want 55", rd1_zb);
        end
        checks++;
        if (rd1 !== 32'h1234) begin
            errors++;
            $display("FAIL bypass_new_value got %h want 1234", rd1);
        end
        cyc();
        we1 = 1'b0;
        #4;
        checks++;
        if (rd1_zb !== 32'h1234) begin
            errors++;
            $display("FAIL nobypass_next_cycle got %h want 1234", rd1_zb);
        end
    endtask

    // Fill every entry with its index, restart the clear, then reset again
    // twenty cycles into the clear. The array must come back all-zero.
    task automatic test_mid_reset();
        for (int i = 0; i < 32; i++) begin
            cyc();
            we1 = 1'b1; wa1 = 6'(2 * i);     wd1 = 32'(2 * i);
            we2 = 1'b1; wa2 = 6'(2 * i + 1); wd2 = 32'(2 * i + 1);
        end
        cyc();
        we1 = 1'b0; we2 = 1'b0;
        ra1 = 6'd63; ra2 = 6'd10;
        #1;
        checks++;
        if (rd1 !== 32'd63 || rd2 !== 32'd10 || rd1_zb !== 32'd63) begin
            errors++;
            $display("FAIL fill_readback got %h %h %h want 3f 0a 3f", rd1, rd2, rd1_zb);
        end
        ra1 = 6'd0;
        #1;
        checks++;
        if (rd1 !== 32'd0 || rd1_zy !== 32'd0) begin
            errors++;
            $display("FAIL fill_entry0 got %h %h want 0 0", rd1, rd1_zy);
        end
        rst = 1'b1;
        we2 = 1'b1; wa2 = 6'd40; wd2 = 32'h99;
        cyc();
        rst = 1'b0;
        we2 = 1'b0;
        repeat (20) cyc();
        ra1 = 6'd63;
        #1;
        checks++;
        if (ready !== 1'b0 || rd1 !== 32'h0) begin
            errors++;
            $display("FAIL clear_gates_read got ready=%b rd1=%h want 0 0", ready, rd1);
        end
        reset_and_wait("mid_reset");
        check_all_zero("mid_reset");
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_no_bypass();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
